// File: rtl/floor_call_panel.sv
// Call-button latch for the 5-floor elevator controller: holds per-floor requests,
// opens the door for a fixed dwell once the car settles at a requested floor.
module floor_call_panel #(
    parameter int SETTLE = 2,
    parameter int DWELL  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn,
    input  logic [2:0] floor,
    output logic       ra,
    output logic       rb,
    output logic       rc,
    output logic       rd,
    output logic       re,
    output logic       door_open,
    output logic [2:0] pending
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int DW = $clog2(DWELL);

    typedef enum logic {IDLE, OPEN} state_t;

    state_t          state;
    logic [4:0]      req;
    logic [4:0]      btn_q;
    logic            armed;
    logic [2:0]      floor_q;
    logic [SW-1:0]   stable_cnt;
    logic [DW-1:0]   dwell_cnt;

    logic            floor_legal;
    logic            floor_same;
    logic            settled;
    logic [4:0]      floor_onehot;
    logic [4:0]      press;
    logic            here_press;
    logic            here_req;
    logic [4:0]      clr;
    logic [4:0]      req_next;

    function automatic logic [2:0] popcount5(input logic [4:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 5; i++) n = n + 3'(v[i]);
        return n;
    endfunction

    // armed stays low for the first cycle out of reset so a button already held
    // while reset releases is absorbed into btn_q instead of counting as a press.
    assign press        = btn & ~btn_q & {5{armed}};
    assign floor_legal  = (floor <= 3'd4);
    assign floor_same   = (floor == floor_q);
    assign floor_onehot = floor_legal ? (5'b00001 << floor) : 5'b00000;
    assign settled      = floor_legal && floor_same && (stable_cnt == SW'(SETTLE));
    assign here_press   = |(press & floor_onehot);
    assign here_req     = |(req & floor_onehot);

    // NOTE: every signal driven in always_comb gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    always_comb begin
        clr = 5'b00000;
        if (state == OPEN && floor_same && !here_press && dwell_cnt == '0)
            clr = floor_onehot;
        req_next = (req & ~clr) | press;
    end

    // NOTE: all state below uses non-blocking assignments so every register sees
    // the values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            req        <= '0;
            btn_q      <= '0;
            armed      <= 1'b0;
            floor_q    <= '0;
            stable_cnt <= '0;
            dwell_cnt  <= '0;
            door_open  <= 1'b0;
            pending    <= '0;
        end else begin
            btn_q   <= btn;
            armed   <= 1'b1;
            floor_q <= floor;
            req     <= req_next;
            pending <= popcount5(req_next);

            if (!floor_legal || !floor_same)
                stable_cnt <= '0;
            else if (stable_cnt != SW'(SETTLE))
                stable_cnt <= stable_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (settled && here_req) begin
                        state     <= OPEN;
                        dwell_cnt <= DW'(DWELL - 1);
                        door_open <= 1'b1;
                    end
                end
                OPEN: begin
                    // Car moved away: abandon service and keep the request latched.
                    if (!floor_same) begin
                        state     <= IDLE;
                        door_open <= 1'b0;
                    end else if (here_press) begin
                        dwell_cnt <= DW'(DWELL - 1);
                    end else if (dwell_cnt == '0) begin
                        state     <= IDLE;
                        door_open <= 1'b0;
                    end else begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    door_open <= 1'b0;
                end
            endcase
        end
    end

    assign {re, rd, rc, rb, ra} = req;

endmodule

// File: tb/tb_floor_call_panel.sv
// Directed bench for floor_call_panel: vector table for reset, single service and
// travel, then hand sequences for abort, extension, collision, illegal floor, reset.
module tb_floor_call_panel;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn;
    logic [2:0] floor;
    logic       ra, rb, rc, rd, re;
    logic       door_open;
    logic [2:0] pending;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       r;
        logic [4:0] b;
        logic [2:0] f;
        logic [4:0] exp_req;
        logic       exp_door;
        logic [2:0] exp_pend;
    } vec_t;

    vec_t vecs[$];

    floor_call_panel #(.SETTLE(2), .DWELL(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .floor     (floor),
        .ra        (ra),
        .rb        (rb),
        .rc        (rc),
        .rd        (rd),
        .re        (re),
        .door_open (door_open),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic r, input logic [4:0] b, input logic [2:0] f,
                               input logic [4:0] er, input logic ed, input logic [2:0] ep);
        vec_t t;
        t.r = r; t.b = b; t.f = f; t.exp_req = er; t.exp_door = ed; t.exp_pend = ep;
        return t;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [4:0] er, input logic ed,
                             input logic [2:0] ep);
        check({tag, " req"},     8'({re, rd, rc, rb, ra}), 8'(er));
        check({tag, " door"},    8'(door_open), 8'(ed));
        check({tag, " pending"}, 8'(pending), 8'(ep));
    endtask

    // Drive inputs, let one rising edge pass, sample 1 time unit later.
    task automatic cyc(input logic r, input logic [4:0] b, input logic [2:0] f);
        rst = r; btn = b; floor = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; btn = '0; floor = 3'd0;

        // Reset with buttons held, release without edges, then single service at 2.
        for (int i = 0; i < 3; i++) vecs.push_back(v(0, 5'h1F, 2, 5'h00, 0, 0));
        vecs.push_back(v(1, 5'h1F, 2, 5'h00, 0, 0));
        vecs.push_back(v(1, 5'h1F, 2, 5'h00, 0, 0));
        vecs.push_back(v(1, 5'h00, 2, 5'h00, 0, 0));
        vecs.push_back(v(1, 5'h00, 2, 5'h00, 0, 0));
        vecs.push_back(v(1, 5'h04, 2, 5'h04, 0, 1));
        vecs.push_back(v(1, 5'h04, 2, 5'h04, 1, 1));
        for (int i = 0; i < 7; i++) vecs.push_back(v(1, 5'h00, 2, 5'h04, 1, 1));
        vecs.push_back(v(1, 5'h00, 2, 5'h00, 0, 0));
        vecs.push_back(v(1, 5'h00, 2, 5'h00, 0, 0));
        // Travel 0 -> 1 -> 2 with rc latched; door three edges after reaching 2.
        vecs.push_back(v(1, 5'h04, 0, 5'h04, 0, 1));
        vecs.push_back(v(1, 5'h00, 1, 5'h04, 0, 1));
        vecs.push_back(v(1, 5'h00, 2, 5'h04, 0, 1));
        vecs.push_back(v(1, 5'h00, 2, 5'h04, 0, 1));
        vecs.push_back(v(1, 5'h00, 2, 5'h04, 0, 1));
        vecs.push_back(v(1, 5'h00, 2, 5'h04, 1, 1));
        vecs.push_back(v(1, 5'h00, 2, 5'h04, 1, 1));

        foreach (vecs[i]) begin
            cyc(vecs[i].r, vecs[i].b, vecs[i].f);
            check_all($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_door,
                      vecs[i].exp_pend);
        end

        // Abort: car leaves floor 2 mid-dwell.
        cyc(1, 5'h00, 3); check_all("abort", 5'h04, 0, 1);
        cyc(1, 5'h00, 3); check_all("abort_idle", 5'h04, 0, 1);

        // Return to 2, reopen, then extend at dwell count 3.
        for (int i = 0; i < 3; i++) begin
            cyc(1, 5'h00, 2); check_all($sformatf("ret%0d", i), 5'h04, 0, 1);
        end
        cyc(1, 5'h00, 2); check_all("reopen", 5'h04, 1, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 5'h00, 2); check_all($sformatf("pre_ext%0d", i), 5'h04, 1, 1);
        end
        cyc(1, 5'h04, 2); check_all("extend", 5'h04, 1, 1);
        for (int i = 0; i < 7; i++) begin
            cyc(1, 5'h00, 2); check_all($sformatf("ext%0d", i), 5'h04, 1, 1);
        end
        cyc(1, 5'h00, 2); check_all("ext_close", 5'h00, 0, 0);

        // Collision: presses at 0 and 4 during service, re-press 2 on final dwell cycle.
        cyc(1, 5'h04, 2); check_all("col_req", 5'h04, 0, 1);
        cyc(1, 5'h00, 2); check_all("col_open", 5'h04, 1, 1);
        cyc(1, 5'h11, 2); check_all("col_others", 5'h15, 1, 3);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 5'h00, 2); check_all($sformatf("col_run%0d", i), 5'h15, 1, 3);
        end
        cyc(1, 5'h04, 2); check_all("col_last", 5'h15, 1, 3);
        for (int i = 0; i < 7; i++) begin
            cyc(1, 5'h00, 2); check_all($sformatf("col_ext%0d", i), 5'h15, 1, 3);
        end
        cyc(1, 5'h00, 2); check_all("col_close", 5'h11, 0, 2);

        // Illegal floor value never opens the door nor touches requests.
        for (int i = 0; i < 10; i++) begin
            cyc(1, 5'h00, 6); check_all($sformatf("illegal%0d", i), 5'h11, 0, 2);
        end

        // Arrive at floor 0, then reset mid-dwell.
        for (int i = 0; i < 3; i++) begin
            cyc(1, 5'h00, 0); check_all($sformatf("arr0_%0d", i), 5'h11, 0, 2);
        end
        cyc(1, 5'h00, 0); check_all("open0", 5'h11, 1, 2);
        cyc(0, 5'h00, 0); check_all("rst_mid", 5'h00, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 5'h00, 0); check_all($sformatf("post_rst%0d", i), 5'h00, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/floor_call_panel.md
# floor_call_panel

Call-side companion to the 5-floor elevator controller. Latches floor-button presses into the controller's one-hot-per-floor request lines `ra`..`re` and watches the controller's `floor` output. When the car settles at a requested floor, the block opens the door for a fixed dwell and then clears that floor's request. It sits between the button inputs and the controller: it drives the controller's request inputs and consumes its `floor` output.

## Interface
- `SETTLE`, 2: consecutive cycles `floor` must hold one value before arrival is declared (≥1).
- `DWELL`, 8: cycles `door_open` stays high per service (≥2).
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-low.
- `btn`  in  5  raw call buttons, bit0 = floor 0 (A) … bit4 = floor 4 (E); level, may stay high across many cycles.
- `floor`  in  3  current floor from the controller, 0..4; values 5..7 are illegal.
- `ra`,`rb`,`rc`,`rd`,`re`  out  1 each  latched requests for floors 0..4, registered.
- `door_open`  out  1  door open at current floor, registered.
- `pending`  out  3  population count of `{re,rd,rc,rb,ra}`, 0..5, registered.

## Operation
- Reset (`rst`=0 at posedge): all requests 0, `door_open`=0, `pending`=0, state IDLE, stable counter 0, dwell counter 0, `btn` edge register 0.
- Press detection: rising edge per bit (`btn` & ~`btn_q`). An edge sets that floor's request bit. A held button generates no further edges.
- Stable tracking: `floor_q` is `floor` registered. The stable counter resets to 0 when `floor` ≠ `floor_q`. Otherwise it increments, saturating at `SETTLE`. "Settled" means counter = `SETTLE`.
- Illegal `floor` (5..7): never settled, never matches a request. Requests are unaffected.
- FSM, 2 states:
  - IDLE: if settled and the request bit at `floor` is set → OPEN. Load dwell counter with `DWELL`-1 and set `door_open`=1.
  - OPEN: decrement dwell counter each cycle.
    - A new edge on the current floor's button reloads `DWELL`-1 (extends the dwell; the request stays set).
    - If the counter is 0 and there is no reload: clear the current floor's request, set `door_open`=0, return to IDLE.
    - If `floor` changes while in OPEN: abort. Set `door_open`=0, return to IDLE, request not cleared.
- Set/clear collision on the same bit in the same cycle: set wins.
- Requests at other floors may be latched in any state. They are never cleared except by service at that floor or by reset.
- `pending` is recomputed from the next-state request vector, so it is coherent with `ra`..`re` on the same cycle.
- The controller holds the car while the request at its floor is set. The request therefore stays high for the whole dwell, and is dropped on the same edge as `door_open` falls.

## Timing
- Edge on `btn[i]` sampled at edge N → request bit i and `pending` update at N+1.
- Arrival: `floor` first shows value f at edge N. Settled at N+`SETTLE`. `door_open`=1 at N+`SETTLE`+1, provided f was already requested.
- A request set while the car is already settled at f opens the door one cycle after the request bit rises.
- `door_open` is high for exactly `DWELL` cycles absent extension/abort. The request for f clears on the same edge `door_open` falls.
- Back-to-back: after the door closes, the FSM returns to IDLE. If f is requested again later, reopening needs one IDLE cycle (the request must be re-set first).
- Reset mid-OPEN: the next cycle shows all outputs at reset values. No service is completed.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `btn`=5'b11111 → all outputs 0. Release with `btn` still held → no request sets (no edge).
- Single service, `floor`=2 stable, pulse `btn[2]` at cycle 10 → `rc`=1 and `pending`=1 at 11; `door_open` high cycles 12..19; `rc`=0 and `pending`=0 at 20.
- Travel: `floor` stepping 0→1→2 with a change every cycle, `rc` set → no door at 1; door opens 3 cycles after `floor` reaches 2 (`SETTLE`=2).
- Extension: re-press `btn[2]` at dwell count 3 → counter reloads; `door_open` high 8 more cycles from the reload.
- Abort: `floor` changes 2→3 mid-OPEN → `door_open`=0 next cycle, `rc` still 1, `pending` unchanged.
- Collision: pulse `btn[0]` and `btn[4]` while serving floor 2, plus a `btn[2]` edge on the final dwell cycle → `pending` reads 3, then stays 3 (`rc` kept, door extended); illegal `floor`=6 for 10 cycles → no `door_open`.
